updown_counter_param: RTL and testbench

- Parametrised synchronous up/down counter. It is the next generation of the fixed 4-bit down counter.
- Adds: programmable width and ceiling, direction control, count enable, parallel load, and three boundary modes (wrap, saturate, one-shot).
- Used as a general timebase, event counter or reload timer in datapath and control blocks.
- Single clock domain; all outputs are registered except the boundary flags.

---
 rtl/updown_counter_param.sv | 170 +++++++++++++++++
 tb/tb_updown_counter_param.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// ----------------------------------------------------------------------------
// updown_counter_param
//
// Parametrised synchronous up/down counter with a programmable ceiling, count
// enable, parallel load and three boundary behaviours:
//   wrap      (mode 00, and the reserved code 11) - roll over at the boundary
//   saturate  (mode 01)                           - stick at the boundary
//   one-shot  (mode 10)                           - count once after a load
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   en        count enable, one step per clock while high
//   dir       0 = count down, 1 = count up
//   mode      boundary behaviour select (see above)
//   load      synchronous parallel load strobe (beats en)
//   load_val  value to load; values above MAX_VAL are clamped to MAX_VAL
//   counter   current count (registered)
//   tc        terminal-count pulse (registered)
//   at_zero   combinational flag: counter == 0
//   at_max    combinational flag: counter == MAX_VAL
//   busy      one-shot sequence in progress (registered)
// ----------------------------------------------------------------------------
module updown_counter_param #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_VAL   = (1 << WIDTH) - 1,
    parameter int unsigned RESET_VAL = MAX_VAL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             at_zero,
    output logic             at_max,
    output logic             busy
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RESET_VAL);

    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] counter_reg, counter_next;
    logic             tc_reg, tc_next;
    logic             busy_reg, busy_next;

    // Datapath helpers, evaluated one bit wider than the counter so that the
    // ceiling comparison and the +/-1 step can never silently overflow.
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH:0]   boundary_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] wrap_val;
    logic [WIDTH-1:0] load_clamped;
    logic             at_bound;
    logic             step_hits;
    logic             one_shot;

    always_comb begin
        cnt_ext      = {1'b0, counter_reg};
        load_ext     = {1'b0, load_val};
        load_clamped = (load_ext > MAX_EXT) ? MAX_W : load_val;
        boundary_ext = dir ? MAX_EXT : '0;
        at_bound     = (cnt_ext == boundary_ext);
        step_ext     = dir ? (cnt_ext + (WIDTH + 1)'(1)) : (cnt_ext - (WIDTH + 1)'(1));
        step_val     = step_ext[WIDTH-1:0];
        // True when this step lands exactly on the boundary.
        step_hits    = (step_ext == boundary_ext);
        wrap_val     = dir ? '0 : MAX_W;
        one_shot     = (mode == MODE_ONESHOT);
    end

    // Next-state logic. Stepping is only ever done when not at the boundary,
    // so the counter cannot leave the range 0..MAX_VAL.
    always_comb begin
        counter_next = counter_reg;
        tc_next      = 1'b0;
        state_next   = state_reg;
        busy_next    = 1'b0;

        if (load) begin
            counter_next = load_clamped;
            if (one_shot) begin
                state_next = ST_RUN;
                busy_next  = 1'b1;
            end else begin
                state_next = ST_IDLE;
            end
        end else if (!one_shot && (state_reg != ST_IDLE)) begin
            // Left one-shot mode mid-sequence: spend this edge returning the
            // FSM to IDLE with the counter frozen.
            state_next = ST_IDLE;
        end else if (one_shot) begin
            case (state_reg)
                ST_RUN: begin
                    busy_next = 1'b1;
                    if (en) begin
                        if (at_bound) begin
                            // Loaded right at the boundary: finish without moving.
                            tc_next    = 1'b1;
                            state_next = ST_DONE;
                            busy_next  = 1'b0;
                        end else begin
                            counter_next = step_val;
                            if (step_hits) begin
                                tc_next    = 1'b1;
                                state_next = ST_DONE;
                                busy_next  = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    // IDLE and DONE hold until a load.
                end
            endcase
        end else if (en) begin
            if (mode == MODE_SAT) begin
                if (!at_bound) begin
                    counter_next = step_val;
                    // Pulse only on arrival; a held boundary stays quiet.
                    tc_next      = step_hits;
                end
            end else begin
                if (at_bound) begin
                    counter_next = wrap_val;
                    tc_next      = 1'b1;
                end else begin
                    counter_next = step_val;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_reg <= RST_W;
            tc_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            state_reg   <= ST_IDLE;
        end else begin
            counter_reg <= counter_next;
            tc_reg      <= tc_next;
            busy_reg    <= busy_next;
            state_reg   <= state_next;
        end
    end

    assign counter = counter_reg;
    assign tc      = tc_reg;
    assign busy    = busy_reg;
    assign at_zero = (counter_reg == '0);
    assign at_max  = (counter_reg == MAX_W);

endmodule

// File: tb/tb_updown_counter_param.sv
// ----------------------------------------------------------------------------
// tb_updown_counter_param
//
// Directed bench for updown_counter_param. Two instances share the stimulus:
//   dut_a : WIDTH=4, full range 0..15, reset value 15
//   dut_b : WIDTH=4, ceiling 9, reset value 9
// Each vector names which instance it checks. Multi-cycle corner cases
// (asynchronous reset between edges) are written out by hand at the end.
// ----------------------------------------------------------------------------
module tb_updown_counter_param;

    logic       clk;
    logic       reset;
    logic       en;
    logic       dir;
    logic [1:0] mode;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] cnt_a, cnt_b;
    logic       tc_a, tc_b;
    logic       zero_a, zero_b;
    logic       max_a, max_b;
    logic       busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    updown_counter_param #(.WIDTH(4)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .counter  (cnt_a),
        .tc       (tc_a),
        .at_zero  (zero_a),
        .at_max   (max_a),
        .busy     (busy_a)
    );

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .counter  (cnt_b),
        .tc       (tc_b),
        .at_zero  (zero_b),
        .at_max   (max_b),
        .busy     (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sel;      // 0 = dut_a, 1 = dut_b
        logic       load;
        logic [3:0] load_val;
        logic       en;
        logic       dir;
        logic [1:0] mode;
        logic [3:0] exp_cnt;
        logic       exp_tc;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s, input logic ld, input logic [3:0] lv,
                                input logic e, input logic d, input logic [1:0] m,
                                input logic [3:0] c, input logic t, input logic b);
        vec_t v;
        v.sel = s; v.load = ld; v.load_val = lv; v.en = e; v.dir = d; v.mode = m;
        v.exp_cnt = c; v.exp_tc = t; v.exp_busy = b;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d] got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Checks every output of one instance against an expected count/tc/busy.
    // at_zero / at_max expectations follow from the expected count and ceiling.
    task automatic chk_dut(input logic s, input int idx, input logic [3:0] c,
                           input logic t, input logic b);
        logic [3:0] ceil_v;
        ceil_v = s ? 4'd9 : 4'd15;
        if (!s) begin
            chk("a_counter", idx, cnt_a, c);
            chk("a_tc",      idx, {3'b0, tc_a},   {3'b0, t});
            chk("a_busy",    idx, {3'b0, busy_a}, {3'b0, b});
            chk("a_at_zero", idx, {3'b0, zero_a}, {3'b0, (c == 4'd0)});
            chk("a_at_max",  idx, {3'b0, max_a},  {3'b0, (c == ceil_v)});
        end else begin
            chk("b_counter", idx, cnt_b, c);
            chk("b_tc",      idx, {3'b0, tc_b},   {3'b0, t});
            chk("b_busy",    idx, {3'b0, busy_b}, {3'b0, b});
            chk("b_at_zero", idx, {3'b0, zero_b}, {3'b0, (c == 4'd0)});
            chk("b_at_max",  idx, {3'b0, max_b},  {3'b0, (c == ceil_v)});
        end
    endtask

    task automatic drive(input logic ld, input logic [3:0] lv, input logic e,
                         input logic d, input logic [1:0] m);
        @(negedge clk);
        load = ld; load_val = lv; en = e; dir = d; mode = m;
    endtask

    task automatic step_and_check(input logic s, input int idx, input logic [3:0] c,
                                  input logic t, input logic b);
        @(posedge clk);
        #1;
        $display("txn %0d dut_%s load=%0b lv=%0h en=%0b dir=%0b mode=%0d -> cnt=%0h tc=%0b busy=%0b (exp %0h %0b %0b)",
                 idx, s ? "b" : "a", load, load_val, en, dir, mode,
                 s ? cnt_b : cnt_a, s ? tc_b : tc_a, s ? busy_b : busy_a, c, t, b);
        chk_dut(s, idx, c, t, b);
    endtask

    initial begin
        // ---------------- vector table ----------------
        // Wrap down from F: 17 edges, tc only on the 0 -> F roll-over.
        for (int i = 1; i <= 17; i++) begin
            int c;
            c = (15 - i) & 15;
            add(0, 0, 4'h0, 1, 0, 2'b00, 4'(c), (i == 16), 0);
        end
        // Saturate on dut_b (ceiling 9): clamped load, held at top, run to 0.
        add(1, 1, 4'hC, 0, 1, 2'b01, 4'd9, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 4'h0, 1, 1, 2'b01, 4'd9, 0, 0);
        for (int k = 8; k >= 0; k--) add(1, 0, 4'h0, 1, 0, 2'b01, 4'(k), (k == 0), 0);
        add(1, 0, 4'h0, 1, 0, 2'b01, 4'd0, 0, 0);
        add(1, 0, 4'h0, 1, 0, 2'b01, 4'd0, 0, 0);
        // Saturate upward arrival at the ceiling.
        add(1, 1, 4'h7, 0, 1, 2'b01, 4'd7, 0, 0);
        add(1, 0, 4'h0, 1, 1, 2'b01, 4'd8, 0, 0);
        add(1, 0, 4'h0, 1, 1, 2'b01, 4'd9, 1, 0);
        add(1, 0, 4'h0, 1, 1, 2'b01, 4'd9, 0, 0);
        // One-shot on dut_a: load wins over en, then 3,2,1,0 and stop.
        add(0, 1, 4'h3, 1, 0, 2'b10, 4'd3, 0, 1);
        add(0, 0, 4'h0, 1, 0, 2'b10, 4'd2, 0, 1);
        add(0, 0, 4'h0, 1, 0, 2'b10, 4'd1, 0, 1);
        add(0, 0, 4'h0, 1, 0, 2'b10, 4'd0, 1, 0);
        add(0, 0, 4'h0, 1, 0, 2'b10, 4'd0, 0, 0);
        add(0, 0, 4'h0, 1, 0, 2'b10, 4'd0, 0, 0);
        add(0, 1, 4'h5, 0, 0, 2'b10, 4'd5, 0, 1);
        add(0, 0, 4'h0, 1, 0, 2'b10, 4'd4, 0, 1);
        // Mode change while in RUN: one frozen edge, then normal wrap counting.
        add(0, 0, 4'h0, 1, 0, 2'b00, 4'd4, 0, 0);
        add(0, 0, 4'h0, 1, 0, 2'b00, 4'd3, 0, 0);
        // One-shot loaded at the boundary: first en edge fires with no move.
        add(0, 1, 4'h0, 0, 0, 2'b10, 4'd0, 0, 1);
        add(0, 0, 4'h0, 1, 0, 2'b10, 4'd0, 1, 0);
        add(0, 0, 4'h0, 1, 0, 2'b10, 4'd0, 0, 0);
        // RUN with en low holds.
        add(0, 1, 4'h6, 0, 0, 2'b10, 4'd6, 0, 1);
        add(0, 0, 4'h0, 0, 0, 2'b10, 4'd6, 0, 1);
        add(0, 0, 4'h0, 1, 0, 2'b10, 4'd5, 0, 1);
        // Priority: load + en together, then en low with dir toggling.
        add(0, 1, 4'h7, 1, 0, 2'b00, 4'd7, 0, 0);
        add(0, 0, 4'h0, 0, 1, 2'b00, 4'd7, 0, 0);
        add(0, 0, 4'h0, 0, 0, 2'b00, 4'd7, 0, 0);
        add(0, 0, 4'h0, 0, 1, 2'b00, 4'd7, 0, 0);
        // Wrap upward through F -> 0, and a same-edge direction change.
        add(0, 1, 4'hE, 0, 1, 2'b00, 4'hE, 0, 0);
        add(0, 0, 4'h0, 1, 1, 2'b00, 4'hF, 0, 0);
        add(0, 0, 4'h0, 1, 1, 2'b00, 4'h0, 1, 0);
        add(0, 0, 4'h0, 1, 1, 2'b00, 4'h1, 0, 0);
        add(0, 0, 4'h0, 1, 0, 2'b00, 4'h0, 0, 0);
        add(0, 0, 4'h0, 1, 0, 2'b11, 4'hF, 1, 0);   // reserved mode wraps
        // Ceiling-limited wrap on dut_b.
        add(1, 1, 4'h8, 0, 1, 2'b00, 4'd8, 0, 0);
        add(1, 0, 4'h0, 1, 1, 2'b00, 4'd9, 0, 0);
        add(1, 0, 4'h0, 1, 1, 2'b00, 4'd0, 1, 0);
        add(1, 0, 4'h0, 1, 0, 2'b00, 4'd9, 1, 0);
        add(1, 1, 4'hF, 0, 0, 2'b00, 4'd9, 0, 0);

        // ---------------- reset state ----------------
        reset = 1'b1; en = 1'b0; dir = 1'b0; mode = 2'b00; load = 1'b0; load_val = 4'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_dut(0, -1, 4'hF, 0, 0);
        chk_dut(1, -1, 4'd9, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- table loop ----------------
        foreach (vecs[i]) begin
            drive(vecs[i].load, vecs[i].load_val, vecs[i].en, vecs[i].dir, vecs[i].mode);
            step_and_check(vecs[i].sel, i, vecs[i].exp_cnt, vecs[i].exp_tc, vecs[i].exp_busy);
        end

        // ---------------- async reset while counting (wrap) ----------------
        drive(1, 4'hF, 0, 1, 2'b00);
        step_and_check(0, 100, 4'hF, 0, 0);
        drive(0, 4'h0, 1, 1, 2'b00);
        step_and_check(0, 101, 4'h0, 1, 0);
        #2;
        reset = 1'b1;                  // between edges
        #1;
        chk_dut(0, 102, 4'hF, 0, 0);
        chk_dut(1, 102, 4'd9, 0, 0);
        step_and_check(0, 103, 4'hF, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- async reset mid one-shot ----------------
        drive(1, 4'h4, 0, 0, 2'b10);
        step_and_check(0, 110, 4'h4, 0, 1);
        drive(0, 4'h0, 1, 0, 2'b10);
        step_and_check(0, 111, 4'h3, 0, 1);
        step_and_check(0, 112, 4'h2, 0, 1);
        #2;
        reset = 1'b1;
        #1;
        chk_dut(0, 113, 4'hF, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        step_and_check(0, 114, 4'hF, 0, 0);   // IDLE: en alone does nothing
        step_and_check(0, 115, 4'hF, 0, 0);
        drive(1, 4'h2, 0, 0, 2'b10);
        step_and_check(0, 116, 4'h2, 0, 1);
        drive(0, 4'h0, 1, 0, 2'b10);
        step_and_check(0, 117, 4'h1, 0, 1);
        step_and_check(0, 118, 4'h0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
